// File: rtl/mod53_pkg.sv
// Shared constants and types for the {64,63,53} RNS decode path.
package mod53_pkg;
  localparam int M0        = 64;
  localparam int M1        = 63;
  localparam int M2        = 53;
  localparam int INV64_M53 = 29;
  localparam int INV63_M53 = 16;
  localparam int RANGE     = 213696;

  typedef logic [5:0] res_t;

  typedef enum logic [2:0] {IDLE, S_A2, S_M29, S_M16, S_SUM, DONE} state_t;
endpackage

// File: rtl/mod53_cmul_reduce.sv
// y = (a*k) mod 53, combinational; restoring reduction by 53*2^i for i=5..0.
module mod53_cmul_reduce
  import mod53_pkg::*;
(
  input  logic [5:0] a,
  input  logic [4:0] k,
  output res_t       y
);
  logic [10:0] acc;

  always_comb begin
    acc = {5'd0, a} * {6'd0, k};
    for (int i = 5; i >= 0; i--) begin
      if (acc >= 11'(M2 << i)) acc = acc - 11'(M2 << i);
    end
    y = acc[5:0];
  end
endmodule

// File: rtl/mod53_rns_decoder.sv
// Residue-to-binary decoder for RNS {64,63,53} by sequential mixed-radix conversion.
// Six-state loop: result valid in the 5th cycle after the triple is presented.
module mod53_rns_decoder
  import mod53_pkg::*;
#(
  parameter int OUT_W = 18,
  parameter int RES_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] r64,
  input  logic [RES_W-1:0] r63,
  input  logic [RES_W-1:0] r53,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);
  state_t     state;
  res_t       q64, q63, q53;
  logic       err;
  res_t       a1, a2, a3, d, t;

  res_t       cm_a, cm_y;
  logic [4:0] cm_k;
  logic [6:0] df2, dfd, dfm;
  res_t       a2_n, d_n, a2m, dm;
  logic [OUT_W-1:0] sum;

  // One multiplier/reducer, its operands steered by state.
  mod53_cmul_reduce u_cmul (.a(cm_a), .k(cm_k), .y(cm_y));

  always_comb begin
    cm_a = '0;
    cm_k = 5'd1;
    case (state)
      S_A2:    begin cm_a = q64; cm_k = 5'd1;                end
      S_M29:   begin cm_a = d;   cm_k = 5'(INV64_M53);       end
      S_M16:   begin cm_a = dm;  cm_k = 5'(INV63_M53);       end
      default: begin cm_a = '0;  cm_k = 5'd1;                end
    endcase
  end

  always_comb begin
    // a2 = (r63 - r64) mod 63; 63 itself folds to 0
    df2 = {1'b0, q63} - {1'b0, q64};
    if (df2[6]) df2 = df2 + 7'd63;
    if (df2 == 7'd63) df2 = 7'd0;
    a2_n = df2[5:0];

    dfd = {1'b0, q53} - {1'b0, cm_y};
    if (dfd[6]) dfd = dfd + 7'd53;
    d_n = dfd[5:0];

    a2m = (a2 >= 6'd53) ? a2 - 6'd53 : a2;
    dfm = {1'b0, t} - {1'b0, a2m};
    if (dfm[6]) dfm = dfm + 7'd53;
    dm = dfm[5:0];

    sum = OUT_W'(a1) + (OUT_W'(a2) << 6) + (OUT_W'(a3) << 12) - (OUT_W'(a3) << 6);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      q64 <= '0; q63 <= '0; q53 <= '0; err <= 1'b0;
      a1  <= '0; a2  <= '0; a3  <= '0; d   <= '0; t <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          q64      <= r64;
          q63      <= r63;
          q53      <= r53;
          err      <= (r63 > 6'd62) | (r53 > 6'd52);
          in_ready <= 1'b0;
          state    <= S_A2;
        end
        S_A2: begin
          a1    <= q64;
          a2    <= a2_n;
          d     <= d_n;
          state <= S_M29;
        end
        S_M29: begin
          t     <= cm_y;
          state <= S_M16;
        end
        S_M16: begin
          a3    <= cm_y;
          state <= S_SUM;
        end
        S_SUM: begin
          out_data  <= err ? '0 : sum;
          out_err   <= err;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mod53_rns_decoder.sv
// Scoreboard bench for mod53_rns_decoder: expected {err,X} queued at issue, checked at output handshake.
module tb_mod53_rns_decoder;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [5:0]  r64 = '0, r63 = '0, r53 = '0;
  logic        in_ready, out_valid, out_err;
  logic [17:0] out_data;

  int checks = 0, failures = 0;
  int cyc = 0, issue_cyc = 0, xfer_cyc = 0, prev_xfer = -1, nhs = 0, h0 = 0;
  logic chk_ii = 1'b0, ov_q = 1'b0;
  logic [18:0] sb[$];
  logic [18:0] e;

  mod53_rns_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .r64(r64), .r63(r63), .r53(r53), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !ov_q) chk("latency", cyc - issue_cyc, 5);
      if (out_valid && out_ready) begin
        nhs++;
        if (sb.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = sb.pop_front();
          chk("out_data", 32'(out_data), 32'(e[17:0]));
          chk("out_err", 32'(out_err), 32'(e[18]));
        end
      end
    end
    ov_q = out_valid;
  end

  task automatic send(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                      input logic [17:0] xd, input logic xe);
    int n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (n >= 100) chk("in_ready_timeout", 0, 1);
    r64 = a; r63 = b; r53 = c; in_valid = 1'b1;
    issue_cyc = cyc;
    sb.push_back({xe, xd});
    tick();
    xfer_cyc = cyc;
    in_valid = 1'b0;
    if (chk_ii && prev_xfer >= 0) chk("ii", xfer_cyc - prev_xfer, 6);
    prev_xfer = xfer_cyc;
  endtask

  task automatic send_x(input int x);
    send(6'(x % 64), 6'(x % 63), 6'(x % 53), 18'(x), 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin tick(); n++; end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    tick();
  endtask

  initial begin
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_err", 32'(out_err), 0);
    rst = 1'b0;
    tick();

    send(6'd0, 6'd0, 6'd0, 18'd0, 1'b0);
    drain();
    send(6'd63, 6'd62, 6'd52, 18'd213695, 1'b0);
    send(6'd32, 6'd19, 6'd42, 18'd100000, 1'b0);
    send(6'd0, 6'd1, 6'd11, 18'd64, 1'b0);
    send(6'd5, 6'd5, 6'd53, 18'd0, 1'b1);
    send(6'd5, 6'd63, 6'd0, 18'd0, 1'b1);
    drain();

    // backpressure: result must hold and new requests must be ignored
    out_ready = 1'b0;
    send_x(12345);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
    end
    chk("bp_valid", 32'(out_valid), 1);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; r64 = 6'd1; r63 = 6'd2; r53 = 6'd3;
      tick();
      chk("bp_hold_data", 32'(out_data), 12345);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_valid_hold", 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    h0 = nhs;
    out_ready = 1'b1;
    tick();
    chk("bp_one_xfer", nhs - h0, 1);
    chk("bp_in_ready_after", 32'(in_ready), 1);
    chk("bp_valid_after", 32'(out_valid), 0);
    chk("bp_data_kept", 32'(out_data), 12345);
    for (int i = 0; i < 8; i++) tick();

    // reset while in S_M29 aborts the conversion
    send_x(777);
    tick();
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_in_ready", 32'(in_ready), 1);
    sb.delete();
    tick();
    rst = 1'b0;
    prev_xfer = -1;
    for (int i = 0; i < 8; i++) tick();
    chk("abort_no_out", 32'(out_valid), 0);
    send(6'd32, 6'd19, 6'd42, 18'd100000, 1'b0);
    drain();

    chk_ii = 1'b1;
    prev_xfer = -1;
    for (int i = 0; i < 40; i++) send_x(int'($urandom_range(0, 213695)));
    chk_ii = 1'b0;
    drain();

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
